// File: rtl/imgproc_core.sv
// imgproc_core: 2x2 Bayer demosaic with 2x decimation in X and Y.
// Bayer layout: (even y, even x)=G1, (even y, odd x)=R, (odd y, even x)=B,
// (odd y, odd x)=G2. A single-row line buffer keeps the previous row, so a
// quad completes on the odd/odd pixel and one RGB sample comes out per quad.
// Optional build macro IMGPROC_GRAY_EN: all three outputs carry the
// four-pixel average instead of the colour values.
// Handshake: input is valid-only (no back-pressure). A beat is taken on any
// rising edge with iDVAL=1 while iRST=1; oDVAL is a one-cycle pulse that
// qualifies oRed/oGreen/oBlue, which otherwise hold their last values.
module imgproc_core #(
  parameter int LINE_WIDTH = 1280
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic [11:0] iDATA,
  input  logic        iDVAL,
  output logic [11:0] oRed,
  output logic [11:0] oGreen,
  output logic [11:0] oBlue,
  output logic        oDVAL
);

  localparam int          AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [11:0] LW = 12'(LINE_WIDTH);

  logic [11:0]   r_line_buf [0:LINE_WIDTH-1];
  logic [11:0]   r_prev;
  logic [11:0]   r_above_prev;
  logic [11:0]   r_red;
  logic [11:0]   r_green;
  logic [11:0]   r_blue;
  logic          r_dval;

  logic          w_accept;
  logic          w_in_range;
  logic          w_quad;
  logic [AW-1:0] w_addr;
  logic [11:0]   w_rd;
  logic [11:0]   w_out_r;
  logic [11:0]   w_out_g;
  logic [11:0]   w_out_b;
  logic          w_unused_ok;

  // Only the row parity is needed from the row counter.
  assign w_unused_ok = ^iY_Cont[10:1];

  assign w_accept   = iRST & iDVAL;
  assign w_in_range = ({1'b0, iX_Cont} < LW);
  assign w_addr     = iX_Cont[AW-1:0];
  assign w_quad     = w_accept & w_in_range & iX_Cont[0] & iY_Cont[0];

  // Previous-row pixel at the current column; zero for out-of-range columns.
  always_comb begin
    w_rd = '0;
    if (w_in_range) w_rd = r_line_buf[w_addr];
  end

  // Quad pixels: G1=r_above_prev, R=w_rd, B=r_prev, G2=iDATA.
`ifdef IMGPROC_GRAY_EN
  logic [13:0] w_all_sum;
  logic [13:0] w_avg;
  always_comb begin
    w_all_sum = {2'b00, r_above_prev} + {2'b00, w_rd} + {2'b00, r_prev} + {2'b00, iDATA};
    w_avg     = w_all_sum >> 2;
    w_out_r   = w_avg[11:0];
    w_out_g   = w_avg[11:0];
    w_out_b   = w_avg[11:0];
  end
  logic w_unused_avg;
  assign w_unused_avg = ^w_avg[13:12];
`else
  logic [12:0] w_g_sum;
  logic [12:0] w_g_half;
  always_comb begin
    w_g_sum  = {1'b0, r_above_prev} + {1'b0, iDATA};
    w_g_half = w_g_sum >> 1;
    w_out_r  = w_rd;
    w_out_g  = w_g_half[11:0];
    w_out_b  = r_prev;
  end
  logic w_unused_half;
  assign w_unused_half = w_g_half[12];
`endif

  // Line buffer: read-before-write, never cleared by reset.
  always_ff @(posedge iCLK) begin
    if (w_accept && w_in_range) r_line_buf[w_addr] <= iDATA;
  end

  // Pixel history and registered outputs; reset drops any partial quad.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_prev       <= '0;
      r_above_prev <= '0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
      r_dval       <= 1'b0;
    end else begin
      r_dval <= w_quad;
      if (w_accept) begin
        r_prev       <= iDATA;
        r_above_prev <= w_rd;
      end
      if (w_quad) begin
        r_red   <= w_out_r;
        r_green <= w_out_g;
        r_blue  <= w_out_b;
      end
    end
  end

  assign oRed   = r_red;
  assign oGreen = r_green;
  assign oBlue  = r_blue;
  assign oDVAL  = r_dval;

endmodule

// File: tb/tb_imgproc_core.sv
// Bench for imgproc_core on an 8x6 frame with an 8-pixel line buffer.
// Reference model keeps the driven image as a 2D array and forms each
// quad directly from the four neighbouring pixels.
module tb_imgproc_core;

  localparam int W = 8;
  localparam int H = 6;

  // Clock / reset
  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [10:0] iX_Cont = '0;
  logic [10:0] iY_Cont = '0;
  logic [11:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDVAL;

  always #5 iCLK = ~iCLK;

  imgproc_core #(.LINE_WIDTH(W)) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .oRed    (oRed),
    .oGreen  (oGreen),
    .oBlue   (oBlue),
    .oDVAL   (oDVAL)
  );

  // Reference model state
  logic [11:0] pix [0:H-1][0:W-1];
  logic [11:0] exp_r = '0;
  logic [11:0] exp_g = '0;
  logic [11:0] exp_b = '0;
  logic        exp_v = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int pulse_cnt;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Update the model for one edge, drive it, then compare #1 after the edge.
  task automatic step(input int x, input int y, input logic [11:0] d,
                      input logic v, input logic rst);
    int g1, r, b, g2;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iDATA   = d;
    iDVAL   = v;
    iRST    = rst;
    if (!rst) begin
      exp_v = 1'b0;
      exp_r = '0;
      exp_g = '0;
      exp_b = '0;
    end else begin
      exp_v = 1'b0;
      if (v && x < W) begin
        pix[y][x] = d;
        if ((x % 2 == 1) && (y % 2 == 1)) begin
          g1 = int'(pix[y-1][x-1]);
          r  = int'(pix[y-1][x]);
          b  = int'(pix[y][x-1]);
          g2 = int'(d);
          exp_v = 1'b1;
`ifdef IMGPROC_GRAY_EN
          exp_r = 12'((g1 + r + b + g2) / 4);
          exp_g = exp_r;
          exp_b = exp_r;
`else
          exp_r = 12'(r);
          exp_g = 12'((g1 + g2) / 2);
          exp_b = 12'(b);
`endif
        end
      end
    end
    @(posedge iCLK);
    #1;
    if (oDVAL === 1'b1) pulse_cnt++;
    chk("dval",  {11'd0, oDVAL}, {11'd0, exp_v});
    chk("red",   oRed,   exp_r);
    chk("green", oGreen, exp_g);
    chk("blue",  oBlue,  exp_b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 2047), $urandom_range(0, 2047),
           12'($urandom_range(0, 4095)), 1'b0, 1'b1);
  endtask

  // mode 0: ramp 8y+x+1; mode 1: random with gap, reset and
  // out-of-range beats; mode 2: random with random idle gaps.
  task automatic run_frame(input int mode, input bit first);
    logic [11:0] d;
    pulse_cnt = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        d = (mode == 0) ? 12'(8 * y + x + 1) : 12'($urandom_range(0, 4095));
        step(x, y, d, 1'b1, 1'b1);
        if (mode == 0 && first && x == 1 && y == 1) begin
`ifdef IMGPROC_GRAY_EN
          chk("first_red",   oRed,   12'h005);
          chk("first_green", oGreen, 12'h005);
          chk("first_blue",  oBlue,  12'h005);
`else
          chk("first_red",   oRed,   12'h002);
          chk("first_green", oGreen, 12'h005);
          chk("first_blue",  oBlue,  12'h009);
`endif
        end
`ifndef IMGPROC_GRAY_EN
        if (mode == 0 && x == 7 && y == 5) begin
          chk("last_red",  oRed,  12'h028);
          chk("last_blue", oBlue, 12'h02F);
        end
`endif
        if (mode == 1 && y == 3 && x == 2) idle(3);
        if (mode == 1 && y == 3 && x == 3)
          step(4, 3, 12'($urandom_range(0, 4095)), 1'b1, 1'b0);
      end
      if (mode >= 1) begin
        if (y % 2 == 0) begin
          step(W + 1, y, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        end else begin
          step(W,     y, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
          step(W + 1, y, 12'($urandom_range(0, 4095)), 1'b1, 1'b1);
        end
      end
    end
    chk("pulse_count", 12'(pulse_cnt), 12'd12);
  endtask

  // Directed sequence
  initial begin
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix[y][x] = '0;

    // Reset with live-looking input: nothing may be accepted.
    step(1, 1, 12'hABC, 1'b1, 1'b0);
    step(0, 0, 12'h123, 1'b1, 1'b0);

    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(0, 1'b0);

    // Reset directly after a quad output clears the outputs.
    step(3, 3, 12'h7FF, 1'b1, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
